// File: rtl/ext_result_collector_if.sv
// ----------------------------------------------------------------------------
// ext_result_collector_if
//   Bundles the external result stream and the output-buffer SRAM write port
//   seen by ext_result_collector.
//
//   Stream (producer -> collector), no backpressure:
//     ext_valid_i   beat valid
//     ext_result_i  beat data, DRIVER_WIDTH bits
//   Memory write port (collector -> SRAM), active-low strobes:
//     mem_cenb_o    chip enable, active-low
//     mem_wenb_o    write enable, active-low
//     mem_addr_o    row address, AW bits
//     mem_d_o       row write data, RW bits
//
//   Handshake: a beat transfers in every cycle ext_valid_i is high; the
//   collector has no ready signal and never stalls the producer. A memory
//   write takes place in every cycle mem_cenb_o and mem_wenb_o are both low.
//
//   Modports:
//     slave  - the collector (consumes the stream, drives the memory port)
//     master - the stream producer / memory model (testbench side)
// ----------------------------------------------------------------------------
interface ext_result_collector_if #(
    parameter int DRIVER_WIDTH = 8,
    parameter int RW           = 32,
    parameter int AW           = 8
) ();
    logic                    ext_valid_i;
    logic [DRIVER_WIDTH-1:0] ext_result_i;
    logic                    mem_cenb_o;
    logic                    mem_wenb_o;
    logic [AW-1:0]           mem_addr_o;
    logic [RW-1:0]           mem_d_o;

    modport slave (
        input  ext_valid_i,
        input  ext_result_i,
        output mem_cenb_o,
        output mem_wenb_o,
        output mem_addr_o,
        output mem_d_o
    );

    modport master (
        output ext_valid_i,
        output ext_result_i,
        input  mem_cenb_o,
        input  mem_wenb_o,
        input  mem_addr_o,
        input  mem_d_o
    );
endinterface

// File: rtl/ext_result_collector.sv
// ----------------------------------------------------------------------------
// ext_result_collector
//   Receive end of the matrix-multiply wrapper's external result stream.
//   DRIVER_WIDTH-bit beats are packed LSB-first into COL*WIDTH-bit rows and
//   every completed row is written into an output-buffer SRAM. A run ends
//   after an expected number of rows or when a stop code arrives at beat 0.
//
//   Ports:
//     clk_i          clock
//     rstn_async_i   asynchronous active-low reset
//     en_i           block enable; low freezes all state and masks writes
//     start_i        one-cycle pulse: clear counters, load config, COLLECT
//     base_addr_i    first destination row (sampled on start_i)
//     exp_rows_i     rows to collect, 0 = unlimited (sampled on start_i)
//     stop_en_i      enable stop-code termination (sampled on start_i)
//     stop_code_i    stop code value (sampled on start_i)
//     bus            stream in / SRAM write port (slave modport)
//     row_cnt_o      rows written since start_i
//     busy_o         high in COLLECT
//     done_o         high in DONE until the next start_i
//     overflow_o     sticky; a write landed past the wrap of O_SIZE-1
//     state_dbg_o    current FSM state (IDLE=0, COLLECT=1, DONE=2)
// ----------------------------------------------------------------------------
module ext_result_collector #(
    parameter  int WIDTH        = 8,
    parameter  int COL          = 4,
    parameter  int DRIVER_WIDTH = 8,
    parameter  int O_SIZE       = 256,
    localparam int RW           = COL * WIDTH,
    localparam int AW           = $clog2(O_SIZE)
) (
    input  logic                    clk_i,
    input  logic                    rstn_async_i,
    input  logic                    en_i,
    input  logic                    start_i,
    input  logic [AW-1:0]           base_addr_i,
    input  logic [AW:0]             exp_rows_i,
    input  logic                    stop_en_i,
    input  logic [DRIVER_WIDTH-1:0] stop_code_i,
    ext_result_collector_if.slave   bus,
    output logic [AW:0]             row_cnt_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o,
    output logic [1:0]              state_dbg_o
);

    localparam int BEATS = RW / DRIVER_WIDTH;
    localparam int BIW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BIW-1:0] LAST_BEAT = BIW'(BEATS - 1);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(O_SIZE - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]              r_state;
    logic [BIW-1:0]          r_beat_idx;
    logic [RW-1:0]           r_shift;
    logic [AW-1:0]           r_addr;
    logic                    r_wrapped;
    logic [AW:0]             r_row_cnt;
    logic [AW:0]             r_exp_rows;
    logic                    r_stop_en;
    logic [DRIVER_WIDTH-1:0] r_stop_code;
    logic                    r_overflow;
    logic                    r_cenb;
    logic                    r_wenb;
    logic [AW-1:0]           r_mem_addr;
    logic [RW-1:0]           r_mem_d;

    logic                    w_beat_ok;
    logic                    w_stop_hit;
    logic [AW:0]             w_row_cnt_inc;
    logic [RW-1:0]           w_shift_next;

    // start_i takes priority, so a beat arriving with it is dropped.
    assign w_beat_ok     = (r_state == S_COLLECT) && bus.ext_valid_i && !start_i;
    assign w_stop_hit    = w_beat_ok && r_stop_en && (r_beat_idx == '0) &&
                           (bus.ext_result_i == r_stop_code);
    assign w_row_cnt_inc = r_row_cnt + 1'b1;

    // Row image with the current beat dropped into its slot; on the last
    // beat this is exactly the row that goes to memory.
    always_comb begin
        w_shift_next = r_shift;
        w_shift_next[r_beat_idx*DRIVER_WIDTH +: DRIVER_WIDTH] = bus.ext_result_i;
    end

    always_ff @(posedge clk_i or negedge rstn_async_i) begin
        if (!rstn_async_i) begin
            r_state     <= S_IDLE;
            r_beat_idx  <= '0;
            r_shift     <= '0;
            r_addr      <= '0;
            r_wrapped   <= 1'b0;
            r_row_cnt   <= '0;
            r_exp_rows  <= '0;
            r_stop_en   <= 1'b0;
            r_stop_code <= '0;
            r_overflow  <= 1'b0;
            r_cenb      <= 1'b1;
            r_wenb      <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_d     <= '0;
        end else if (en_i) begin
            // A write strobe lasts one enabled cycle; while en_i is low the
            // strobe register holds so the write goes out on re-enable.
            r_cenb <= 1'b1;
            r_wenb <= 1'b1;
            if (start_i) begin
                r_state     <= S_COLLECT;
                r_beat_idx  <= '0;
                r_shift     <= '0;
                r_addr      <= base_addr_i;
                r_wrapped   <= 1'b0;
                r_row_cnt   <= '0;
                r_exp_rows  <= exp_rows_i;
                r_stop_en   <= stop_en_i;
                r_stop_code <= stop_code_i;
                r_overflow  <= 1'b0;
            end else if (w_stop_hit) begin
                // The stop beat itself is never stored.
                r_state <= S_DONE;
            end else if (w_beat_ok) begin
                r_shift <= w_shift_next;
                if (r_beat_idx == LAST_BEAT) begin
                    r_beat_idx <= '0;
                    r_cenb     <= 1'b0;
                    r_wenb     <= 1'b0;
                    r_mem_addr <= r_addr;
                    r_mem_d    <= w_shift_next;
                    r_row_cnt  <= w_row_cnt_inc;
                    // Overflow flags the first write that lands on a
                    // wrapped address, not the wrap itself.
                    if (r_wrapped) begin
                        r_overflow <= 1'b1;
                    end
                    if (r_addr == LAST_ADDR) begin
                        r_addr    <= '0;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                    if ((r_exp_rows != '0) && (w_row_cnt_inc == r_exp_rows)) begin
                        r_state <= S_DONE;
                    end
                end else begin
                    r_beat_idx <= r_beat_idx + 1'b1;
                end
            end
        end
    end

    assign bus.mem_cenb_o = r_cenb | ~en_i;
    assign bus.mem_wenb_o = r_wenb | ~en_i;
    assign bus.mem_addr_o = r_mem_addr;
    assign bus.mem_d_o    = r_mem_d;

    assign row_cnt_o   = r_row_cnt;
    assign busy_o      = (r_state == S_COLLECT);
    assign done_o      = (r_state == S_DONE);
    assign overflow_o  = r_overflow;
    assign state_dbg_o = r_state;

endmodule

// File: tb/tb_ext_result_collector.sv
// ----------------------------------------------------------------------------
// tb_ext_result_collector
//   Directed bench for ext_result_collector (WIDTH=8, COL=4, DRIVER_WIDTH=8,
//   O_SIZE=256). A row-level reference model tracks collected beats, the
//   rows written and the expected writes; one compare process checks the
//   outputs every cycle, and directed literal checks pin the model.
// ----------------------------------------------------------------------------
module tb_ext_result_collector;

  localparam int BEATS  = 4;
  localparam int O_SIZE = 256;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] exp_rows = '0;
  logic       stop_en = 1'b0;
  logic [7:0] stop_code = '0;
  logic [8:0] row_cnt;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [1:0] state_dbg;

  int tests = 0;
  int fails = 0;

  ext_result_collector_if #(.DRIVER_WIDTH(8), .RW(32), .AW(8)) bus ();

  ext_result_collector #(
    .WIDTH(8), .COL(4), .DRIVER_WIDTH(8), .O_SIZE(O_SIZE)
  ) dut (
    .clk_i        (clk),
    .rstn_async_i (rstn),
    .en_i         (en),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .exp_rows_i   (exp_rows),
    .stop_en_i    (stop_en),
    .stop_code_i  (stop_code),
    .bus          (bus.slave),
    .row_cnt_o    (row_cnt),
    .busy_o       (busy),
    .done_o       (done),
    .overflow_o   (overflow),
    .state_dbg_o  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_state: 0 idle, 1 collecting, 2 done
  int         m_state = 0;
  logic [7:0] m_beats[$];
  int         m_base = 0;
  int         m_rows = 0;
  int         m_exp = 0;
  bit         m_stop_en = 0;
  logic [7:0] m_stop_code = '0;
  bit         m_over = 0;
  bit         m_pend = 0;
  logic [39:0] exp_q[$];   // {addr, row data}

  task automatic model_reset();
    m_state = 0;
    m_beats.delete();
    m_rows = 0;
    m_over = 0;
    m_pend = 0;
    exp_q.delete();
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_reset();
    end else if (en) begin
      logic [31:0] row;
      int lin;
      // Any write shown during an enabled cycle has now happened.
      m_pend = 0;
      if (start) begin
        m_state = 1;
        m_beats.delete();
        m_base = int'(base_addr);
        m_rows = 0;
        m_exp = int'(exp_rows);
        m_stop_en = stop_en;
        m_stop_code = stop_code;
        m_over = 0;
      end else if (m_state == 1 && bus.ext_valid_i) begin
        if (m_stop_en && m_beats.size() == 0 && bus.ext_result_i == m_stop_code) begin
          m_state = 2;
        end else begin
          m_beats.push_back(bus.ext_result_i);
          if (m_beats.size() == BEATS) begin
            row = '0;
            for (int k = 0; k < BEATS; k++) row[k*8 +: 8] = m_beats[k];
            lin = m_base + m_rows;
            if (lin >= O_SIZE) m_over = 1;
            exp_q.push_back({8'(lin % O_SIZE), row});
            m_pend = 1;
            m_rows++;
            m_beats.delete();
            if (m_exp != 0 && m_rows == m_exp) m_state = 2;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int          wr_cnt = 0;
  logic [7:0]  last_addr = '0;
  logic [31:0] last_d = '0;

  always @(negedge clk) begin
    logic exp_wr;
    logic [39:0] e;
    exp_wr = m_pend && en && rstn;
    chk("cenb", bus.mem_cenb_o, !exp_wr);
    chk("wenb", bus.mem_wenb_o, !exp_wr);
    chk("row_cnt", row_cnt, 9'(m_rows));
    chk("busy", busy, m_state == 1);
    chk("done", done, m_state == 2);
    chk("overflow", overflow, m_over);
    if (!bus.mem_cenb_o) begin
      wr_cnt++;
      last_addr = bus.mem_addr_o;
      last_d = bus.mem_d_o;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.mem_addr_o, e[39:32]);
        chk("wr_data", bus.mem_d_o, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] n,
                          input logic se, input logic [7:0] sc);
    start = 1'b1;
    base_addr = b;
    exp_rows = n;
    stop_en = se;
    stop_code = sc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input int gap);
    bus.ext_valid_i = 1'b0;
    repeat (gap) tick();
    bus.ext_valid_i = 1'b1;
    bus.ext_result_i = d;
    tick();
    bus.ext_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk(name, done, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int wr0;

  initial begin
    bus.ext_valid_i = 1'b0;
    bus.ext_result_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cenb", bus.mem_cenb_o, 1);
    chk("rst_wenb", bus.mem_wenb_o, 1);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_d", bus.mem_d_o, 0);
    chk("rst_row_cnt", row_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    rstn = 1'b1;
    tick();

    // T1: single row, count termination on the write
    do_start(8'h10, 9'd1, 1'b0, 8'h00);
    send_beat(8'h11, 0);
    send_beat(8'h22, 0);
    send_beat(8'h33, 0);
    send_beat(8'h44, 0);
    chk("t1_cenb", bus.mem_cenb_o, 0);
    chk("t1_wenb", bus.mem_wenb_o, 0);
    chk("t1_addr", bus.mem_addr_o, 8'h10);
    chk("t1_d", bus.mem_d_o, 32'h44332211);
    chk("t1_row_cnt", row_cnt, 1);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    tick();

    // T2: three rows with random valid gaps
    wr0 = wr_cnt;
    do_start(8'h10, 9'd3, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) send_beat(8'h50 + 8'(i), $urandom_range(0, 2));
    wait_done("t2_done_timeout");
    tick();
    chk("t2_writes", wr_cnt - wr0, 3);
    chk("t2_last_addr", last_addr, 8'h12);
    chk("t2_last_d", last_d, 32'h5B5A5958);

    // T3: stop code at beat 0 after two rows
    wr0 = wr_cnt;
    do_start(8'h20, 9'd0, 1'b1, 8'hFF);
    for (int i = 1; i <= 8; i++) send_beat(8'(i), 0);
    send_beat(8'hFF, 0);
    chk("t3_done", done, 1);
    chk("t3_row_cnt", row_cnt, 2);
    send_beat(8'h77, 0);
    tick();
    chk("t3_writes", wr_cnt - wr0, 2);
    chk("t3_last_d", last_d, 32'h08070605);

    // T3b: stop code value at beat 2 is plain data
    do_start(8'h30, 9'd0, 1'b1, 8'hFF);
    send_beat(8'hA0, 0);
    send_beat(8'hA1, 0);
    send_beat(8'hFF, 0);
    send_beat(8'hA3, 0);
    tick();
    chk("t3b_d_byte2", last_d[23:16], 8'hFF);
    chk("t3b_d", last_d, 32'hA3FFA1A0);
    chk("t3b_busy", busy, 1);
    send_beat(8'hFF, 1);
    chk("t3b_done", done, 1);
    chk("t3b_row_cnt", row_cnt, 1);

    // T4: address wrap and overflow
    do_start(8'hFE, 9'd3, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) send_beat(8'h80 + 8'(i), 0);
    chk("t4_ovf_after_2nd", overflow, 0);
    chk("t4_addr_2nd", bus.mem_addr_o, 8'hFF);
    for (int i = 8; i < 12; i++) send_beat(8'h80 + 8'(i), 0);
    chk("t4_ovf_3rd", overflow, 1);
    chk("t4_addr_3rd", bus.mem_addr_o, 8'h00);
    chk("t4_done", done, 1);
    tick();

    // T5: reset mid-row
    do_start(8'h40, 9'd1, 1'b0, 8'h00);
    send_beat(8'hDE, 0);
    send_beat(8'hAD, 0);
    rstn = 1'b0;
    #1;
    chk("t5_cenb", bus.mem_cenb_o, 1);
    chk("t5_wenb", bus.mem_wenb_o, 1);
    chk("t5_addr", bus.mem_addr_o, 0);
    chk("t5_d", bus.mem_d_o, 0);
    chk("t5_row_cnt", row_cnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ovf", overflow, 0);
    tick();
    rstn = 1'b1;
    tick();
    do_start(8'h40, 9'd1, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) send_beat(8'(i), 0);
    chk("t5_post_d", bus.mem_d_o, 32'h04030201);
    chk("t5_post_cenb", bus.mem_cenb_o, 0);
    tick();

    // T6: enable dropped between last beat and its write
    wr0 = wr_cnt;
    do_start(8'h50, 9'd2, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) send_beat(8'hC0 + 8'(i), 0);
    en = 1'b0;
    bus.ext_valid_i = 1'b1;
    bus.ext_result_i = 8'hEE;
    #1;
    chk("t6_masked_cenb", bus.mem_cenb_o, 1);
    repeat (5) tick();
    chk("t6_no_write", wr_cnt - wr0, 0);
    en = 1'b1;
    bus.ext_valid_i = 1'b0;
    #1;
    chk("t6_reen_cenb", bus.mem_cenb_o, 0);
    chk("t6_reen_addr", bus.mem_addr_o, 8'h50);
    chk("t6_reen_d", bus.mem_d_o, 32'hC3C2C1C0);
    tick();
    for (int i = 4; i < 8; i++) send_beat(8'hC0 + 8'(i), 0);
    wait_done("t6_done_timeout");
    tick();
    chk("t6_writes", wr_cnt - wr0, 2);
    chk("t6_last_d", last_d, 32'hC7C6C5C4);

    // T7: start in the cycle a pending write goes out
    do_start(8'h60, 9'd0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) send_beat(8'h11 + 8'(i), 0);
    do_start(8'h70, 9'd1, 1'b0, 8'h00);
    chk("t7_prev_addr", last_addr, 8'h60);
    chk("t7_row_cnt", row_cnt, 0);
    for (int i = 0; i < 4; i++) send_beat(8'h21 + 8'(i), 0);
    chk("t7_addr", bus.mem_addr_o, 8'h70);
    chk("t7_d", bus.mem_d_o, 32'h24232221);
    chk("t7_done", done, 1);

    repeat (3) tick();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
